// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Definitions shared by the PS/2 host transmitter and its line conditioning:
//   - tx_state_t : transmitter FSM states
//   - err_code_t : abort reason codes reported with tx_error
//   - FRAME_LEN  : bits per host-to-device frame (start, 8 data, parity, stop)
//   - odd_parity / build_frame : helpers that form the outgoing shift word
// ---------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_START,
        ST_WAIT_FIRST,
        ST_DATA,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_ERROR
    } tx_state_t;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_NONE     = 2'b00;
    localparam err_code_t ERR_START_TO = 2'b01;
    localparam err_code_t ERR_XFER_TO  = 2'b10;
    localparam err_code_t ERR_NOACK    = 2'b11;

    // Start bit plus the 10 bits that follow it on the wire.
    localparam int FRAME_LEN = 11;
    localparam int SHIFT_LEN = FRAME_LEN - 1;

    // Number of bits driven after the start bit once the stop bit is out.
    localparam logic [3:0] LAST_BIT = 4'(SHIFT_LEN);

    // Odd parity: data ones plus parity bit always add up to an odd count.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

    // Shift word sent LSB first after the start bit: d0..d7, parity, stop.
    function automatic logic [SHIFT_LEN-1:0] build_frame(input logic [7:0] data);
        return {1'b1, odd_parity(data), data};
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ---------------------------------------------------------------------------
// ps2_host_tx_if
// Command handshake between a requester and the PS/2 host transmitter.
//   tx_valid    : requester wants tx_data sent
//   tx_data     : command byte
//   tx_ready    : transmitter idle, a request is accepted on valid && ready
//   tx_done     : one-cycle pulse, byte sent and acknowledged by the device
//   tx_error    : one-cycle pulse, transfer aborted
//   tx_err_code : abort reason, valid together with tx_error
//   busy        : ~tx_ready, lets the receive path discard frames we caused
// Modports: master = requester side, slave = transmitter side.
// ---------------------------------------------------------------------------
interface ps2_host_tx_if;
    import ps2_pkg::*;

    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_error;
    err_code_t  tx_err_code;
    logic       busy;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready,
        input  tx_done,
        input  tx_error,
        input  tx_err_code,
        input  busy
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready,
        output tx_done,
        output tx_error,
        output tx_err_code,
        output busy
    );

endinterface

// File: rtl/ps2_line_filter.sv
// ---------------------------------------------------------------------------
// ps2_line_filter
// Conditions one raw open-drain PS/2 pad (clock or data): a 2-FF
// synchronizer followed by a stability filter that only changes its output
// after FILTER_CYCLES consecutive synchronized samples disagree with it.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high
//   raw   : asynchronous pad value
//   filt  : filtered line level (1 after reset, an idle PS/2 line is high)
//   fall  : one-cycle strobe in the cycle filt goes 1 -> 0
// ---------------------------------------------------------------------------
module ps2_line_filter #(
    parameter int unsigned FILTER_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic filt,
    output logic fall
);

    localparam int unsigned      CNT_W    = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    // NOTE: every register here uses <= so all flops sample the values from
    // before the edge; with = the synchronizer stages would collapse into one.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= 2'b11;
            cnt  <= '0;
            filt <= 1'b1;
            fall <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            fall <= 1'b0;
            if (sync[1] == filt) begin
                // Any agreeing sample restarts the run, so short glitches vanish.
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt  <= '0;
                filt <= sync[1];
                // Only changes get here, so an old value of 1 means 1 -> 0.
                fall <= filt;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter. Inhibits the bus by holding the clock low,
// presents the start bit, releases the clock and then drives one bit per
// device falling clock edge (d0..d7, odd parity, stop) before sampling the
// device ACK. Only open-drain enables are produced; the pad wrapper drives
// "oe ? 0 : z" and returns the pad level on the *_in ports.
// Ports:
//   CLOCK_50   : system clock (50 MHz)
//   reset      : synchronous, active-high
//   host       : command handshake (ps2_host_tx_if.slave)
//   ps2_clk_in : raw clock pad level
//   ps2_dat_in : raw data pad level
//   ps2_clk_oe : 1 pulls the clock line low
//   ps2_dat_oe : 1 pulls the data line low
// ---------------------------------------------------------------------------
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES       = 5000,
    parameter int unsigned START_TIMEOUT_CYCLES = 750000,
    parameter int unsigned XFER_TIMEOUT_CYCLES  = 100000,
    parameter int unsigned FILTER_CYCLES        = 8
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    ps2_host_tx_if.slave  host,
    input  logic          ps2_clk_in,
    input  logic          ps2_dat_in,
    output logic          ps2_clk_oe,
    output logic          ps2_dat_oe
);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic clk_filt;
    logic clk_fall;
    logic dat_filt;

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filter (
        .clk   (CLOCK_50),
        .reset (reset),
        .raw   (ps2_clk_in),
        .filt  (clk_filt),
        .fall  (clk_fall)
    );

    // The data line is only sampled as a level; its fall strobe is not needed.
    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_dat_filter (
        .clk   (CLOCK_50),
        .reset (reset),
        .raw   (ps2_dat_in),
        .filt  (dat_filt),
        .fall  ()
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    tx_state_t            state,     state_n;
    logic [SHIFT_LEN-1:0] shift_q,   shift_n;
    logic [3:0]           bitcnt,    bitcnt_n;
    logic                 clk_oe_q,  clk_oe_n;
    logic                 dat_oe_q,  dat_oe_n;
    logic                 done_q,    done_n;
    logic                 error_q,   error_n;
    err_code_t            err_code_q, err_code_n;
    logic [31:0]          cyc_cnt;
    logic [31:0]          xfer_cnt;

    logic accept;
    logic start_to;
    logic xfer_to;
    logic no_ack;

    // States covered by the transfer watchdog.
    function automatic logic in_xfer(input tx_state_t s);
        return (s == ST_DATA) || (s == ST_ACK) || (s == ST_WAIT_IDLE);
    endfunction

    assign host.tx_ready    = (state == ST_IDLE) && !reset;
    assign host.busy        = ~host.tx_ready;
    assign host.tx_done     = done_q;
    assign host.tx_error    = error_q;
    assign host.tx_err_code = err_code_q;
    assign ps2_clk_oe       = clk_oe_q;
    assign ps2_dat_oe       = dat_oe_q;

    assign accept   = host.tx_valid && host.tx_ready;
    assign start_to = (state == ST_WAIT_FIRST) && (cyc_cnt == START_TIMEOUT_CYCLES - 1);
    assign xfer_to  = in_xfer(state) && (xfer_cnt == XFER_TIMEOUT_CYCLES - 1);

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    // NOTE: every signal assigned below gets a default first, so no path
    // through the case statement leaves one unassigned and infers a latch.
    always_comb begin
        state_n    = state;
        shift_n    = shift_q;
        bitcnt_n   = bitcnt;
        clk_oe_n   = clk_oe_q;
        dat_oe_n   = dat_oe_q;
        done_n     = 1'b0;
        error_n    = 1'b0;
        err_code_n = ERR_NONE;
        no_ack     = 1'b0;

        case (state)
            ST_IDLE: begin
                clk_oe_n = 1'b0;
                dat_oe_n = 1'b0;
                if (accept) begin
                    shift_n  = build_frame(host.tx_data);
                    bitcnt_n = '0;
                    clk_oe_n = 1'b1;
                    state_n  = ST_INHIBIT;
                end
            end

            ST_INHIBIT: begin
                if (cyc_cnt == INHIBIT_CYCLES - 1) begin
                    // Start bit goes out while the clock is still held low.
                    dat_oe_n = 1'b1;
                    state_n  = ST_START;
                end
            end

            ST_START: begin
                clk_oe_n = 1'b0;
                state_n  = ST_WAIT_FIRST;
            end

            ST_WAIT_FIRST, ST_DATA: begin
                // Each device falling edge puts the next bit on the line; the
                // device samples it while its clock is high.
                if (clk_fall) begin
                    dat_oe_n = ~shift_q[0];
                    shift_n  = {1'b0, shift_q[SHIFT_LEN-1:1]};
                    bitcnt_n = bitcnt + 4'd1;
                    if (state == ST_WAIT_FIRST) begin
                        state_n = ST_DATA;
                    end else if (bitcnt_n == LAST_BIT) begin
                        // Stop bit (a released line) is now being driven.
                        state_n = ST_ACK;
                    end
                end
            end

            ST_ACK: begin
                if (clk_fall) begin
                    if (!dat_filt) begin
                        state_n = ST_WAIT_IDLE;
                    end else begin
                        no_ack = 1'b1;
                    end
                end
            end

            ST_WAIT_IDLE: begin
                if (clk_filt && dat_filt) begin
                    done_n  = 1'b1;
                    state_n = ST_IDLE;
                end
            end

            ST_ERROR: begin
                state_n = ST_IDLE;
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Aborts override whatever the case decided, so a timeout landing on
        // the same cycle as a clock fall wins over the bit advance.
        if (start_to || xfer_to || no_ack) begin
            state_n    = ST_ERROR;
            clk_oe_n   = 1'b0;
            dat_oe_n   = 1'b0;
            error_n    = 1'b1;
            err_code_n = start_to ? ERR_START_TO :
                         xfer_to  ? ERR_XFER_TO  : ERR_NOACK;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= ST_IDLE;
            shift_q    <= '0;
            bitcnt     <= '0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            cyc_cnt    <= '0;
            xfer_cnt   <= '0;
        end else begin
            state      <= state_n;
            shift_q    <= shift_n;
            bitcnt     <= bitcnt_n;
            clk_oe_q   <= clk_oe_n;
            dat_oe_q   <= dat_oe_n;
            done_q     <= done_n;
            error_q    <= error_n;
            err_code_q <= err_code_n;

            // Per-state timer restarts on every state entry and rests in IDLE.
            if ((state_n != state) || (state == ST_IDLE)) begin
                cyc_cnt <= '0;
            end else begin
                cyc_cnt <= cyc_cnt + 32'd1;
            end

            // Transfer timer spans DATA through WAIT_IDLE without restarting.
            if (in_xfer(state) && in_xfer(state_n)) begin
                xfer_cnt <= xfer_cnt + 32'd1;
            end else begin
                xfer_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
// Directed bench for ps2_host_tx. A small device model generates the PS/2
// clock (40-cycle period), reads the bits the host drives, and optionally
// returns the ACK. Expected frames are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int H = 20;  // device clock half period in system cycles

    logic CLOCK_50    = 1'b0;
    logic reset       = 1'b1;
    logic ps2_clk_oe;
    logic ps2_dat_oe;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;
    logic clk_line;
    logic dat_line;

    // Open-drain wired-AND of host and device on each line.
    assign clk_line = ~(ps2_clk_oe | dev_clk_low);
    assign dat_line = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx_if host ();

    ps2_host_tx #(
        .INHIBIT_CYCLES       (50),
        .START_TIMEOUT_CYCLES (200),
        .XFER_TIMEOUT_CYCLES  (2000),
        .FILTER_CYCLES        (8)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .host       (host),
        .ps2_clk_in (clk_line),
        .ps2_dat_in (dat_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse and line monitor, sampled on the falling system clock edge.
    int        done_total  = 0;
    int        err_total   = 0;
    int        start_total = 0;
    logic [1:0] err_code_seen  = 2'b00;
    logic       err_clk_oe_seen = 1'b0;
    logic       err_dat_oe_seen = 1'b0;
    logic       clk_oe_prev     = 1'b0;

    always @(negedge CLOCK_50) begin
        if (host.tx_done === 1'b1) done_total++;
        if (host.tx_error === 1'b1) begin
            err_total++;
            err_code_seen   = host.tx_err_code;
            err_clk_oe_seen = ps2_clk_oe;
            err_dat_oe_seen = ps2_dat_oe;
        end
        if (ps2_clk_oe === 1'b1 && clk_oe_prev === 1'b0) start_total++;
        clk_oe_prev = ps2_clk_oe;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic request(input logic [7:0] data);
        host.tx_data  = data;
        host.tx_valid = 1'b1;
        @(negedge CLOCK_50);
        host.tx_valid = 1'b0;
    endtask

    // Waits for the inhibit to start and end; inh = cycles the clock was held.
    task automatic wait_req(output int inh, output bit ok);
        int n = 0;
        inh = 0;
        while (ps2_clk_oe !== 1'b1 && n < 20) begin
            @(negedge CLOCK_50);
            n++;
        end
        while (ps2_clk_oe === 1'b1 && inh < 1000) begin
            @(negedge CLOCK_50);
            inh++;
        end
        ok = (n < 20) && (ps2_clk_oe === 1'b0);
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (host.tx_ready !== 1'b1 && n < 200) begin
            @(negedge CLOCK_50);
            n++;
        end
        ok = (host.tx_ready === 1'b1);
    endtask

    // Device model: clocks the frame, reads bits just before each rising
    // edge, optionally glitches the clock high phase after fall glitch_after,
    // stops early after fall stop_after, and returns the ACK if asked.
    task automatic dev_frame(input bit give_ack, input int glitch_after, input int stop_after,
                             output logic [9:0] bits, output logic start_bit);
        bits      = '0;
        start_bit = dat_line;
        repeat (H) @(negedge CLOCK_50);
        for (int k = 1; k <= 10; k++) begin
            dev_clk_low = 1'b1;
            repeat (H - 1) @(negedge CLOCK_50);
            bits[k-1] = dat_line;
            @(negedge CLOCK_50);
            dev_clk_low = 1'b0;
            if (k == glitch_after) begin
                repeat (12) @(negedge CLOCK_50);
                dev_clk_low = 1'b1;
                repeat (3) @(negedge CLOCK_50);
                dev_clk_low = 1'b0;
                repeat (H - 15) @(negedge CLOCK_50);
            end else begin
                repeat (H) @(negedge CLOCK_50);
            end
            if (k == stop_after) return;
        end
        dev_dat_low = give_ack;
        repeat (H) @(negedge CLOCK_50);
        dev_clk_low = 1'b1;
        repeat (H) @(negedge CLOCK_50);
        dev_clk_low = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        dev_dat_low = 1'b0;
    endtask

    initial begin
        int         inh;
        int         n;
        bit         ok;
        logic [9:0] bits;
        logic       sb;
        int         d0;
        int         e0;
        int         s0;

        host.tx_valid = 1'b0;
        host.tx_data  = 8'h00;

        // ---------------- reset state ----------------
        repeat (3) @(negedge CLOCK_50);
        check("ready_in_reset", host.tx_ready, 1'b0);
        check("busy_in_reset", host.busy, 1'b1);
        reset = 1'b0;
        @(negedge CLOCK_50);
        check("ready_after_reset", host.tx_ready, 1'b1);
        check("busy_after_reset", host.busy, 1'b0);
        check("clk_oe_after_reset", ps2_clk_oe, 1'b0);
        check("dat_oe_after_reset", ps2_dat_oe, 1'b0);
        check("done_after_reset", host.tx_done, 1'b0);
        check("error_after_reset", host.tx_error, 1'b0);
        check("code_after_reset", host.tx_err_code, 2'b00);

        // ---------------- 0xED with ACK ----------------
        d0 = done_total; e0 = err_total;
        request(8'hED);
        wait_req(inh, ok);
        check("ed_req_seen", ok, 1'b1);
        check("ed_inhibit_ge_50", inh >= 50, 1'b1);
        dev_frame(1'b1, 0, 0, bits, sb);
        check("ed_start_bit", sb, 1'b0);
        // d0..d7 = 1,0,1,1,0,1,1,1 ; six ones -> parity 1 ; stop 1
        check("ed_frame_bits", bits, 10'h3ED);
        wait_ready(ok);
        check("ed_ready_back", ok, 1'b1);
        repeat (2) @(negedge CLOCK_50);
        check("ed_done_pulses", done_total - d0, 1);
        check("ed_err_pulses", err_total - e0, 0);

        // ---------------- 0xFF, extra request while busy ----------------
        d0 = done_total; e0 = err_total; s0 = start_total;
        request(8'hFF);
        host.tx_valid = 1'b1;
        host.tx_data  = 8'h00;
        @(negedge CLOCK_50);
        check("ff_ready_low_busy", host.tx_ready, 1'b0);
        repeat (2) @(negedge CLOCK_50);
        host.tx_valid = 1'b0;
        wait_req(inh, ok);
        check("ff_req_seen", ok, 1'b1);
        dev_frame(1'b1, 0, 0, bits, sb);
        // eight ones -> odd parity bit is 1
        check("ff_frame_bits", bits, 10'h3FF);
        wait_ready(ok);
        check("ff_ready_back", ok, 1'b1);
        repeat (100) @(negedge CLOCK_50);
        check("ff_one_frame", start_total - s0, 1);
        check("ff_done_pulses", done_total - d0, 1);
        check("ff_err_pulses", err_total - e0, 0);

        // ---------------- missing ACK ----------------
        d0 = done_total; e0 = err_total;
        request(8'hED);
        wait_req(inh, ok);
        check("noack_req_seen", ok, 1'b1);
        dev_frame(1'b0, 0, 0, bits, sb);
        wait_ready(ok);
        repeat (2) @(negedge CLOCK_50);
        check("noack_err_pulses", err_total - e0, 1);
        check("noack_code", err_code_seen, 2'b11);
        check("noack_clk_oe", err_clk_oe_seen, 1'b0);
        check("noack_dat_oe", err_dat_oe_seen, 1'b0);
        check("noack_done_pulses", done_total - d0, 0);

        // ---------------- device never clocks ----------------
        d0 = done_total; e0 = err_total;
        request(8'h00);
        wait_req(inh, ok);
        check("sto_req_seen", ok, 1'b1);
        n = 0;
        while (host.tx_error !== 1'b1 && n < 1000) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("sto_cycles", n, 200);
        @(negedge CLOCK_50);
        check("sto_code", err_code_seen, 2'b01);
        check("sto_clk_oe", err_clk_oe_seen, 1'b0);
        check("sto_dat_oe", err_dat_oe_seen, 1'b0);
        check("sto_err_pulses", err_total - e0, 1);
        wait_ready(ok);
        check("sto_ready_back", ok, 1'b1);
        d0 = done_total;
        request(8'h00);
        wait_req(inh, ok);
        check("sto_retry_req_seen", ok, 1'b1);
        dev_frame(1'b1, 0, 0, bits, sb);
        // no ones -> parity 1
        check("sto_retry_bits", bits, 10'h300);
        wait_ready(ok);
        repeat (2) @(negedge CLOCK_50);
        check("sto_retry_done", done_total - d0, 1);

        // ---------------- reset after the 4th data bit ----------------
        d0 = done_total; e0 = err_total;
        request(8'hF4);
        wait_req(inh, ok);
        check("rst_req_seen", ok, 1'b1);
        dev_frame(1'b1, 0, 4, bits, sb);
        // d3 of 0xF4 is 0, so the host is pulling data low here
        check("rst_dat_oe_before", ps2_dat_oe, 1'b1);
        reset = 1'b1;
        @(negedge CLOCK_50);
        check("rst_clk_oe", ps2_clk_oe, 1'b0);
        check("rst_dat_oe", ps2_dat_oe, 1'b0);
        check("rst_ready_low", host.tx_ready, 1'b0);
        @(negedge CLOCK_50);
        reset = 1'b0;
        @(negedge CLOCK_50);
        check("rst_ready_back", host.tx_ready, 1'b1);
        repeat (5) @(negedge CLOCK_50);
        check("rst_no_done", done_total - d0, 0);
        check("rst_no_error", err_total - e0, 0);

        // ---------------- clock glitch during DATA ----------------
        d0 = done_total; e0 = err_total;
        request(8'hF4);
        wait_req(inh, ok);
        check("glitch_req_seen", ok, 1'b1);
        dev_frame(1'b1, 5, 0, bits, sb);
        // five ones -> parity 0
        check("glitch_frame_bits", bits, 10'h2F4);
        wait_ready(ok);
        repeat (2) @(negedge CLOCK_50);
        check("glitch_done", done_total - d0, 1);
        check("glitch_no_error", err_total - e0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
